battery_source_arbiter: RTL and testbench

- Sequences which of two monitored batteries (A, B) drives the shared load, for the battery bench datapath.
- Consumes the same WIDTH-bit charge levels the bench monitors and selects the fullest usable source.
- On depletion, switches break-before-make with a dead gap and a minimum dwell time.
- Raises an alarm when both batteries are low.

---
 rtl/battery_source_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_battery_source_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/battery_source_arbiter.sv
// Two-battery load arbiter: break-before-make switching with dead gap, minimum dwell and low-battery fault.
// Optional BATT_ARB_STATS_EN adds a saturating switch counter output (switch_count).
module battery_source_arbiter #(
  parameter int WIDTH      = 4,
  parameter int LOW_TH     = 2,
  parameter int HYST       = 2,
  parameter int MIN_DWELL  = 8,
  parameter int SWITCH_GAP = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] battA,
  input  logic [WIDTH-1:0] battB,
  output logic             sel_a,
  output logic             sel_b,
  output logic             src_valid,
  output logic             switch_pulse,
  output logic             both_low,
  output logic [WIDTH-1:0] active_level
`ifdef BATT_ARB_STATS_EN
  ,
  output logic [7:0]       switch_count
`endif
);

  localparam int DW = (MIN_DWELL < 1) ? 1 : $clog2(MIN_DWELL + 1);
  localparam int GW = (SWITCH_GAP < 2) ? 1 : $clog2(SWITCH_GAP);

  localparam logic [WIDTH-1:0] LOW_LVL   = WIDTH'(LOW_TH);
  localparam logic [WIDTH:0]   REC_LVL   = (WIDTH + 1)'(LOW_TH + HYST);
  localparam logic [DW-1:0]    DWELL_MAX = DW'(MIN_DWELL);
  localparam logic [GW-1:0]    GAP_LAST  = GW'(SWITCH_GAP - 1);

  typedef enum logic [2:0] {
    IDLE,
    USE_A,
    USE_B,
    GAP_TO_A,
    GAP_TO_B,
    FAULT
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [DW-1:0]    r_dwell;
  logic [DW-1:0]    w_dwell_next;
  logic [GW-1:0]    r_gap;
  logic [GW-1:0]    w_gap_next;
  logic             w_pulse;

  logic             r_sel_a;
  logic             r_sel_b;
  logic             r_valid;
  logic             r_pulse;
  logic             r_fault;
  logic [WIDTH-1:0] r_level;
  logic [WIDTH-1:0] w_level_next;

  logic             w_a_low;
  logic             w_b_low;
  logic             w_a_ge_b;
  logic [WIDTH-1:0] w_max;

  assign w_a_low  = (battA <= LOW_LVL);
  assign w_b_low  = (battB <= LOW_LVL);
  assign w_a_ge_b = (battA >= battB);
  assign w_max    = w_a_ge_b ? battA : battB;

  always_comb begin
    w_next       = r_state;
    w_dwell_next = r_dwell;
    w_gap_next   = r_gap;
    w_pulse      = 1'b0;
    case (r_state)
      IDLE: begin
        if (en) begin
          if (!(w_a_low && w_b_low)) begin
            w_next       = w_a_ge_b ? USE_A : USE_B;
            w_dwell_next = '0;
          end else begin
            w_next = FAULT;
          end
        end
      end
      USE_A: begin
        if (!en) begin
          w_next = IDLE;
        end else if (w_a_low && w_b_low) begin
          w_next = FAULT;
        end else if (!w_b_low && ((battA == '0) || (w_a_low && (r_dwell >= DWELL_MAX)))) begin
          w_next     = GAP_TO_B;
          w_gap_next = '0;
        end else if (r_dwell != DWELL_MAX) begin
          w_dwell_next = r_dwell + 1'b1;
        end
      end
      USE_B: begin
        if (!en) begin
          w_next = IDLE;
        end else if (w_a_low && w_b_low) begin
          w_next = FAULT;
        end else if (!w_a_low && ((battB == '0) || (w_b_low && (r_dwell >= DWELL_MAX)))) begin
          w_next     = GAP_TO_A;
          w_gap_next = '0;
        end else if (r_dwell != DWELL_MAX) begin
          w_dwell_next = r_dwell + 1'b1;
        end
      end
      GAP_TO_A, GAP_TO_B: begin
        // Gap end re-evaluates levels: prefer the target, fall back to the other side.
        if (!en) begin
          w_next = IDLE;
        end else if (r_gap != GAP_LAST) begin
          w_gap_next = r_gap + 1'b1;
        end else if (r_state == GAP_TO_A ? !w_a_low : !w_b_low) begin
          w_next       = (r_state == GAP_TO_A) ? USE_A : USE_B;
          w_dwell_next = '0;
          w_pulse      = 1'b1;
        end else if (r_state == GAP_TO_A ? !w_b_low : !w_a_low) begin
          w_next       = (r_state == GAP_TO_A) ? USE_B : USE_A;
          w_dwell_next = '0;
          w_pulse      = 1'b1;
        end else begin
          w_next = FAULT;
        end
      end
      FAULT: begin
        if (!en || ({1'b0, w_max} > REC_LVL)) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_level_next = '0;
    if (w_next == USE_A) begin
      w_level_next = battA;
    end else if (w_next == USE_B) begin
      w_level_next = battB;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_dwell <= '0;
      r_gap   <= '0;
      r_sel_a <= 1'b0;
      r_sel_b <= 1'b0;
      r_valid <= 1'b0;
      r_pulse <= 1'b0;
      r_fault <= 1'b0;
      r_level <= '0;
    end else begin
      r_state <= w_next;
      r_dwell <= w_dwell_next;
      r_gap   <= w_gap_next;
      r_sel_a <= (w_next == USE_A);
      r_sel_b <= (w_next == USE_B);
      r_valid <= (w_next == USE_A) || (w_next == USE_B);
      r_pulse <= w_pulse;
      r_fault <= (w_next == FAULT);
      r_level <= w_level_next;
    end
  end

  assign sel_a        = r_sel_a;
  assign sel_b        = r_sel_b;
  assign src_valid    = r_valid;
  assign switch_pulse = r_pulse;
  assign both_low     = r_fault;
  assign active_level = r_level;

`ifdef BATT_ARB_STATS_EN
  logic [7:0] r_switch_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_switch_count <= '0;
    end else if (w_pulse && (r_switch_count != 8'hFF)) begin
      r_switch_count <= r_switch_count + 8'd1;
    end
  end

  assign switch_count = r_switch_count;
`endif

endmodule

// File: tb/tb_battery_source_arbiter.sv
// Self-checking bench for battery_source_arbiter: directed scenarios plus random levels against a behavioural model.
module tb_battery_source_arbiter;

  localparam int WIDTH      = 4;
  localparam int LOW_TH     = 2;
  localparam int HYST       = 2;
  localparam int MIN_DWELL  = 8;
  localparam int SWITCH_GAP = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic [WIDTH-1:0] battA = '0;
  logic [WIDTH-1:0] battB = '0;
  logic             sel_a, sel_b, src_valid, switch_pulse, both_low;
  logic [WIDTH-1:0] active_level;
`ifdef BATT_ARB_STATS_EN
  logic [7:0]       switch_count;
`endif

  int total = 0;
  int bad   = 0;

  battery_source_arbiter #(
    .WIDTH(WIDTH), .LOW_TH(LOW_TH), .HYST(HYST),
    .MIN_DWELL(MIN_DWELL), .SWITCH_GAP(SWITCH_GAP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .battA(battA), .battB(battB),
    .sel_a(sel_a), .sel_b(sel_b), .src_valid(src_valid),
    .switch_pulse(switch_pulse), .both_low(both_low), .active_level(active_level)
`ifdef BATT_ARB_STATS_EN
    , .switch_count(switch_count)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural model: which battery feeds the load, how long it has, and any pending gap.
  int   m_src;       // 0 none, 1 battery A, 2 battery B
  bit   m_fault;
  bit   m_pulse;
  int   m_gap_left;  // remaining dead cycles, 0 when not switching
  int   m_gap_tgt;
  int   m_time_on;
  int   m_level;
  int   m_switches;

  function automatic void m_reset();
    m_src = 0; m_fault = 0; m_pulse = 0; m_gap_left = 0;
    m_gap_tgt = 0; m_time_on = 0; m_level = 0; m_switches = 0;
  endfunction

  function automatic void m_update(bit e, int a, int b);
    int lvl[3];
    int mx;
    lvl[0] = 0; lvl[1] = a; lvl[2] = b;
    mx = (a > b) ? a : b;
    m_pulse = 0;
    if (m_gap_left > 0) begin
      if (!e) m_gap_left = 0;
      else if (m_gap_left > 1) m_gap_left--;
      else begin
        m_gap_left = 0;
        if (lvl[m_gap_tgt] > LOW_TH) begin
          m_src = m_gap_tgt; m_pulse = 1; m_time_on = 0;
        end else if (lvl[3 - m_gap_tgt] > LOW_TH) begin
          m_src = 3 - m_gap_tgt; m_pulse = 1; m_time_on = 0;
        end else m_fault = 1;
      end
    end else if (m_fault) begin
      if (!e || mx > LOW_TH + HYST) m_fault = 0;
    end else if (m_src != 0) begin
      int cur, oth;
      cur = lvl[m_src];
      oth = lvl[3 - m_src];
      if (!e) m_src = 0;
      else if (cur <= LOW_TH && oth <= LOW_TH) begin
        m_src = 0; m_fault = 1;
      end else if (oth > LOW_TH && (cur == 0 || (cur <= LOW_TH && m_time_on >= MIN_DWELL))) begin
        m_gap_tgt = 3 - m_src; m_src = 0; m_gap_left = SWITCH_GAP;
      end else m_time_on++;
    end else if (e) begin
      if (mx > LOW_TH) begin
        m_src = (a >= b) ? 1 : 2; m_time_on = 0;
      end else m_fault = 1;
    end
    m_level = (m_src == 0) ? 0 : lvl[m_src];
    if (m_pulse && m_switches < 255) m_switches++;
  endfunction

  function automatic logic [WIDTH+4:0] m_expected();
    logic [WIDTH-1:0] lv;
    lv = WIDTH'(m_level);
    return {m_src == 1, m_src == 2, m_src != 0, m_pulse, m_fault, lv};
  endfunction

  task automatic step(input logic e, input int a, input int b);
    @(negedge clk);
    en = e; battA = WIDTH'(a); battB = WIDTH'(b);
    @(posedge clk);
    m_update(e, a, b);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; en = 1'b0; battA = '0; battB = '0;
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
  endtask

  task automatic test_reset();
    logic [WIDTH+4:0] got;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    got = {sel_a, sel_b, src_valid, switch_pulse, both_low, active_level};
    total++;
    if (got !== '0) begin
      bad++; $display("FAIL reset_outputs: got %b want %b", got, {(WIDTH+5){1'b0}});
    end
`ifdef BATT_ARB_STATS_EN
    total++;
    if (switch_count !== 8'd0) begin
      bad++; $display("FAIL reset_count: got %0d want 0", switch_count);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
  endtask

  task automatic test_select();
    int a_seq[4] = '{7, 7, 5, 5};
    int b_seq[4] = '{3, 3, 5, 5};
    bit e_seq[4] = '{1, 0, 1, 1};
    logic [WIDTH+4:0] got;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(e_seq[i], a_seq[i], b_seq[i]);
      got = {sel_a, sel_b, src_valid, switch_pulse, both_low, active_level};
      total++;
      if (got !== m_expected()) begin
        bad++; $display("FAIL select[%0d]: got %b want %b", i, got, m_expected());
      end
    end
    total++;
    if (!(sel_a === 1'b1 && active_level === 4'd5 && switch_pulse === 1'b0)) begin
      bad++; $display("FAIL select_tie: got sel_a=%b lvl=%0d want sel_a=1 lvl=5", sel_a, active_level);
    end
  endtask

  task automatic test_dwell_switch();
    logic [WIDTH+4:0] got;
    do_reset();
    step(1, 9, 9);
    for (int i = 0; i < 8; i++) step(1, 9, 9);
    for (int i = 0; i < 6; i++) begin
      step(1, 2, 9);
      got = {sel_a, sel_b, src_valid, switch_pulse, both_low, active_level};
      total++;
      if (got !== m_expected()) begin
        bad++; $display("FAIL dwell_switch[%0d]: got %b want %b", i, got, m_expected());
      end
      if (i == 3) begin
        total++;
        if (!(sel_b === 1'b1 && switch_pulse === 1'b1 && active_level === 4'd9)) begin
          bad++; $display("FAIL dwell_arrive: got sel_b=%b pulse=%b lvl=%0d want 1 1 9",
                          sel_b, switch_pulse, active_level);
        end
      end
    end
  endtask

  task automatic test_early_low();
    logic [WIDTH+4:0] got;
    do_reset();
    step(1, 9, 8);
    step(1, 9, 8);
    step(1, 9, 8);
    for (int i = 0; i < 10; i++) begin
      step(1, 2, 8);
      got = {sel_a, sel_b, src_valid, switch_pulse, both_low, active_level};
      total++;
      if (got !== m_expected()) begin
        bad++; $display("FAIL dwell_hold[%0d]: got %b want %b", i, got, m_expected());
      end
    end
    do_reset();
    step(1, 9, 8);
    step(1, 9, 8);
    step(1, 9, 8);
    step(1, 0, 8);
    total++;
    if (!(sel_a === 1'b0 && sel_b === 1'b0 && src_valid === 1'b0)) begin
      bad++; $display("FAIL empty_switch: got sel_a=%b sel_b=%b want 0 0", sel_a, sel_b);
    end
  endtask

  task automatic test_fault();
    int a_seq[5] = '{1, 1, 1, 1, 1};
    int b_seq[5] = '{2, 4, 4, 5, 5};
    logic [WIDTH+4:0] got;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1, a_seq[i], b_seq[i]);
      got = {sel_a, sel_b, src_valid, switch_pulse, both_low, active_level};
      total++;
      if (got !== m_expected()) begin
        bad++; $display("FAIL fault[%0d]: got %b want %b", i, got, m_expected());
      end
    end
    total++;
    if (!(sel_b === 1'b1 && both_low === 1'b0 && active_level === 4'd5)) begin
      bad++; $display("FAIL fault_recover: got sel_b=%b both_low=%b want 1 0", sel_b, both_low);
    end
  endtask

  task automatic test_gap_redirect();
    logic [WIDTH+4:0] got;
    do_reset();
    step(1, 9, 3);
    step(1, 0, 9);
    for (int i = 0; i < 4; i++) begin
      step(1, 6, 1);
      got = {sel_a, sel_b, src_valid, switch_pulse, both_low, active_level};
      total++;
      if (got !== m_expected()) begin
        bad++; $display("FAIL gap_redirect[%0d]: got %b want %b", i, got, m_expected());
      end
    end
    do_reset();
    step(1, 9, 3);
    step(1, 0, 9);
    step(1, 0, 9);
    #2;
    rst_n = 1'b0;
    #1;
    got = {sel_a, sel_b, src_valid, switch_pulse, both_low, active_level};
    total++;
    if (got !== '0 || (sel_a === 1'b1 && sel_b === 1'b1)) begin
      bad++; $display("FAIL reset_mid_gap: got %b want %b", got, {(WIDTH+5){1'b0}});
    end
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 9);
    got = {sel_a, sel_b, src_valid, switch_pulse, both_low, active_level};
    total++;
    if (got !== m_expected()) begin
      bad++; $display("FAIL after_reset: got %b want %b", got, m_expected());
    end
  endtask

  task automatic test_random();
    logic [WIDTH+4:0] got;
    int a = 8, b = 8, errs = 0;
    bit e;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      e = ($urandom_range(0, 29) != 0);
      if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 1) ? $urandom_range(0, 5) : $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 1) ? $urandom_range(0, 5) : $urandom_range(0, 15);
      step(e, a, b);
      got = {sel_a, sel_b, src_valid, switch_pulse, both_low, active_level};
      total++;
      if (got !== m_expected() || (sel_a === 1'b1 && sel_b === 1'b1)) begin
        bad++;
        if (errs < 10) $display("FAIL random[%0d] en=%b a=%0d b=%0d: got %b want %b",
                                i, e, a, b, got, m_expected());
        errs++;
      end
    end
  endtask

`ifdef BATT_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    step(1, 9, 3);
    for (int n = 0; n < 300; n++) begin
      for (int k = 0; k < SWITCH_GAP + 1; k++) begin
        if (n % 2 == 0) step(1, 0, 9);
        else step(1, 9, 0);
      end
    end
    total++;
    if (switch_count !== 8'd255 || m_switches != 255) begin
      bad++; $display("FAIL stats_saturate: got %0d want 255 (model %0d)", switch_count, m_switches);
    end
  endtask
`endif

  initial begin
    m_reset();
    test_reset();
    test_select();
    test_dwell_switch();
    test_early_low();
    test_fault();
    test_gap_redirect();
    test_random();
`ifdef BATT_ARB_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
